// File: rtl/register_bank_mp_pkg.sv
// Shared types and helpers for the multi-read-port register bank.
package regbank_pkg;

  localparam logic ST_CLEAR = 1'b0;
  localparam logic ST_RUN   = 1'b1;

  typedef enum logic {
    S_CLEAR = ST_CLEAR,
    S_RUN   = ST_RUN
  } regbank_state_t;

  localparam int ZERO_REG = 0;

  function automatic int regbank_size(input int bw);
    return 1 << bw;
  endfunction

endpackage

// File: rtl/register_bank_mp_if.sv
// Decode/execute-side bus of the register bank: read ports, write port, soft clear.
interface register_bank_mp_if #(
  parameter int BANK_WIDTH     = 5,
  parameter int REGISTER_WIDTH = 32,
  parameter int NUM_RD_PORTS   = 2
);
  logic [NUM_RD_PORTS*BANK_WIDTH-1:0]     rs_sel;
  logic [NUM_RD_PORTS*REGISTER_WIDTH-1:0] rs_data;
  logic [BANK_WIDTH-1:0]                  rd_sel;
  logic                                   reg_w;
  logic [REGISTER_WIDTH-1:0]              rd_data;
  logic                                   clr;
  logic                                   ready;

  modport master (
    output rs_sel, rd_sel, reg_w, rd_data, clr,
    input  rs_data, ready
  );

  modport slave (
    input  rs_sel, rd_sel, reg_w, rd_data, clr,
    output rs_data, ready
  );
endinterface

// File: rtl/register_bank_mp_clear_seq.sv
// Clear sequencer: walks idx 1..SIZE-1 writing zeros, then flags ready.
module register_bank_clear_seq
  import regbank_pkg::*;
#(
  parameter int BANK_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  output logic                  clr_we,
  output logic [BANK_WIDTH-1:0] clr_idx,
  output logic                  ready
);
  localparam int SIZE  = regbank_size(BANK_WIDTH);
  localparam int IDX_W = BANK_WIDTH + 1;

  regbank_state_t state_q, state_n;
  logic [IDX_W-1:0] idx_q, idx_n;
  logic             ready_q, ready_n;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_CLEAR;
      idx_q   <= IDX_W'(1);
      ready_q <= 1'b0;
    end else begin
      state_q <= state_n;
      idx_q   <= idx_n;
      ready_q <= ready_n;
    end
  end

  always_comb begin
    state_n = state_q;
    idx_n   = idx_q;
    ready_n = ready_q;
    clr_we  = 1'b0;
    clr_idx = idx_q[BANK_WIDTH-1:0];
    unique case (state_q)
      S_CLEAR: begin
        clr_we = 1'b1;
        idx_n  = idx_q + IDX_W'(1);
        // Extra index bit keeps the last-entry compare free of wrap-around.
        if (idx_q == IDX_W'(SIZE - 1)) begin
          state_n = S_RUN;
          ready_n = 1'b1;
        end
      end
      S_RUN: begin
        if (clr) begin
          state_n = S_CLEAR;
          idx_n   = IDX_W'(1);
          ready_n = 1'b0;
        end
      end
      default: ;
    endcase
  end

  assign ready = ready_q;

endmodule

// File: rtl/register_bank_mp.sv
// Integer register bank: NUM_RD_PORTS combinational reads, one write, x0 hardwired to zero.
module register_bank_mp
  import regbank_pkg::*;
#(
  parameter int BANK_WIDTH     = 5,
  parameter int REGISTER_WIDTH = 32,
  parameter int NUM_RD_PORTS   = 2,
  parameter int BYPASS         = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  register_bank_mp_if.slave    bus
);
  localparam int SIZE = regbank_size(BANK_WIDTH);
  localparam logic [BANK_WIDTH-1:0] ZERO_IDX = BANK_WIDTH'(ZERO_REG);

  logic [REGISTER_WIDTH-1:0] mem [SIZE];

  logic                      clr_we;
  logic [BANK_WIDTH-1:0]     clr_idx;
  logic                      ready;
  logic                      port_we;
  logic                      wr_en;
  logic [BANK_WIDTH-1:0]     wr_addr;
  logic [REGISTER_WIDTH-1:0] wr_data;

  register_bank_clear_seq #(.BANK_WIDTH(BANK_WIDTH)) u_clear_seq (
    .clk     (clk),
    .rst     (rst),
    .clr     (bus.clr),
    .clr_we  (clr_we),
    .clr_idx (clr_idx),
    .ready   (ready)
  );

  // ready doubles as "in RUN"; a clear request wins over a same-cycle write.
  assign port_we = ready && !bus.clr && bus.reg_w && (bus.rd_sel != ZERO_IDX);
  assign wr_en   = clr_we || port_we;
  assign wr_addr = clr_we ? clr_idx : bus.rd_sel;
  assign wr_data = clr_we ? '0 : bus.rd_data;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign bus.ready = ready;

  for (genvar k = 0; k < NUM_RD_PORTS; k++) begin : g_rd
    logic [BANK_WIDTH-1:0]     sel;
    logic [REGISTER_WIDTH-1:0] data;

    assign sel = bus.rs_sel[k*BANK_WIDTH +: BANK_WIDTH];

    always_comb begin
      data = '0;
      if (ready && sel != ZERO_IDX) begin
        if (BYPASS != 0 && bus.reg_w && !bus.clr && bus.rd_sel == sel)
          data = bus.rd_data;
        else
          data = mem[sel];
      end
    end

    assign bus.rs_data[k*REGISTER_WIDTH +: REGISTER_WIDTH] = data;
  end

endmodule

// File: tb/tb_register_bank_mp.sv
// Directed bench: a BYPASS=0/2-port bank and a BYPASS=1/4-port bank driven in lockstep.
module tb_register_bank_mp;
  logic        clk;
  logic        rst;
  logic [19:0] rs_sel;
  logic [4:0]  rd_sel;
  logic        reg_w;
  logic [31:0] rd_data;
  logic        clr;

  int n_checks = 0;
  int n_fail   = 0;

  register_bank_mp_if #(.BANK_WIDTH(5), .REGISTER_WIDTH(32), .NUM_RD_PORTS(2)) if0 ();
  register_bank_mp_if #(.BANK_WIDTH(5), .REGISTER_WIDTH(32), .NUM_RD_PORTS(4)) if1 ();

  assign if0.rs_sel  = rs_sel[9:0];
  assign if0.rd_sel  = rd_sel;
  assign if0.reg_w   = reg_w;
  assign if0.rd_data = rd_data;
  assign if0.clr     = clr;
  assign if1.rs_sel  = rs_sel;
  assign if1.rd_sel  = rd_sel;
  assign if1.reg_w   = reg_w;
  assign if1.rd_data = rd_data;
  assign if1.clr     = clr;

  register_bank_mp #(.BANK_WIDTH(5), .REGISTER_WIDTH(32), .NUM_RD_PORTS(2), .BYPASS(0))
    dut0 (.clk(clk), .rst(rst), .bus(if0));
  register_bank_mp #(.BANK_WIDTH(5), .REGISTER_WIDTH(32), .NUM_RD_PORTS(4), .BYPASS(1))
    dut1 (.clk(clk), .rst(rst), .bus(if1));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_sel(input int k, input logic [4:0] v);
    rs_sel[k*5 +: 5] = v;
  endtask

  task automatic do_write(input logic [4:0] a, input logic [31:0] d);
    reg_w = 1'b1; rd_sel = a; rd_data = d;
    tick();
    reg_w = 1'b0;
  endtask

  // Checks ready low after edges 1..30 and high after edge 31.
  task automatic check_clear_window(input string tag);
    for (int e = 1; e <= 31; e++) begin
      tick();
      n_checks++;
      if (if0.ready !== (e == 31) || if1.ready !== (e == 31)) begin
        n_fail++;
        $display("FAIL %s edge %0d: ready0=%b ready1=%b expected %b", tag, e, if0.ready, if1.ready, (e == 31));
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; rs_sel = '0; rd_sel = '0; reg_w = 1'b0; rd_data = '0; clr = 1'b0;
    set_sel(0, 5'd5);
    repeat (3) tick();
    n_checks++;
    if (if0.ready !== 1'b0 || if1.ready !== 1'b0 || if0.rs_data !== 64'h0) begin
      n_fail++;
      $display("FAIL reset_state: ready0=%b ready1=%b rs_data0=%h expected 0", if0.ready, if1.ready, if0.rs_data);
    end
    reg_w = 1'b1; rd_sel = 5'd5; rd_data = 32'hDEAD_BEEF;
    rst = 1'b1;
    check_clear_window("clear_after_reset");
    reg_w = 1'b0;
    for (int i = 0; i < 32; i++) begin
      set_sel(0, 5'(i)); set_sel(1, 5'(31 - i));
      #1;
      n_checks++;
      if (if0.rs_data !== 64'h0 || if1.rs_data[63:0] !== 64'h0) begin
        n_fail++;
        $display("FAIL cleared_x%0d: got %h / %h expected 0", i, if0.rs_data, if1.rs_data[63:0]);
      end
    end
  endtask

  task automatic test_write();
    do_write(5'd3, 32'h1234_5678);
    do_write(5'd0, 32'hFFFF_FFFF);
    do_write(5'd31, 32'hCAFE_0031);
    set_sel(0, 5'd3); set_sel(1, 5'd0); set_sel(2, 5'd31); set_sel(3, 5'd0);
    #1;
    n_checks++;
    if (if0.rs_data !== {32'h0, 32'h1234_5678}) begin
      n_fail++;
      $display("FAIL write_x3_x0: got %h expected %h", if0.rs_data, {32'h0, 32'h1234_5678});
    end
    n_checks++;
    if (if1.rs_data[95:64] !== 32'hCAFE_0031 || if1.rs_data[127:96] !== 32'h0) begin
      n_fail++;
      $display("FAIL write_x31: got %h expected cafe0031/0", if1.rs_data[127:64]);
    end
  endtask

  task automatic test_bypass();
    do_write(5'd7, 32'h0000_0011);
    set_sel(1, 5'd7);
    reg_w = 1'b1; rd_sel = 5'd7; rd_data = 32'hA5A5_A5A5;
    #1;
    n_checks++;
    if (if0.rs_data[63:32] !== 32'h0000_0011) begin
      n_fail++;
      $display("FAIL bypass0_same_cycle: got %h expected 00000011", if0.rs_data[63:32]);
    end
    n_checks++;
    if (if1.rs_data[63:32] !== 32'hA5A5_A5A5) begin
      n_fail++;
      $display("FAIL bypass1_same_cycle: got %h expected a5a5a5a5", if1.rs_data[63:32]);
    end
    tick();
    reg_w = 1'b0;
    #1;
    n_checks++;
    if (if0.rs_data[63:32] !== 32'hA5A5_A5A5 || if1.rs_data[63:32] !== 32'hA5A5_A5A5) begin
      n_fail++;
      $display("FAIL bypass_next_cycle: got %h / %h expected a5a5a5a5", if0.rs_data[63:32], if1.rs_data[63:32]);
    end
  endtask

  task automatic test_multi_port();
    do_write(5'd3, 32'h0BAD_F00D);
    for (int k = 0; k < 4; k++) set_sel(k, 5'd3);
    #1;
    n_checks++;
    if (if1.rs_data !== {4{32'h0BAD_F00D}} || if0.rs_data !== {2{32'h0BAD_F00D}}) begin
      n_fail++;
      $display("FAIL multi_port_same_sel: got %h / %h expected 0badf00d x4", if1.rs_data, if0.rs_data);
    end
  endtask

  task automatic test_clear();
    do_write(5'd9, 32'h0000_0077);
    set_sel(0, 5'd9); set_sel(1, 5'd3);
    clr = 1'b1; reg_w = 1'b1; rd_sel = 5'd9; rd_data = 32'h0000_00FF;
    #1;
    // clr suppresses forwarding even on the bypass bank
    n_checks++;
    if (if1.rs_data[31:0] !== 32'h0000_0077 || if0.rs_data[31:0] !== 32'h0000_0077) begin
      n_fail++;
      $display("FAIL clr_blocks_bypass: got %h / %h expected 00000077", if1.rs_data[31:0], if0.rs_data[31:0]);
    end
    tick();
    clr = 1'b0; reg_w = 1'b0;
    n_checks++;
    if (if0.ready !== 1'b0 || if1.ready !== 1'b0 || if0.rs_data !== 64'h0) begin
      n_fail++;
      $display("FAIL clr_drops_ready: ready0=%b ready1=%b data=%h expected 0", if0.ready, if1.ready, if0.rs_data);
    end
    check_clear_window("soft_clear");
    #1;
    n_checks++;
    if (if0.rs_data !== 64'h0 || if1.rs_data[63:0] !== 64'h0) begin
      n_fail++;
      $display("FAIL soft_clear_x9_x3: got %h / %h expected 0", if0.rs_data, if1.rs_data[63:0]);
    end
  endtask

  task automatic test_async_reset();
    do_write(5'd4, 32'h0000_0044);
    set_sel(0, 5'd4); set_sel(1, 5'd4);
    #1;
    n_checks++;
    if (if0.rs_data !== {2{32'h0000_0044}}) begin
      n_fail++;
      $display("FAIL pre_reset_read: got %h expected 00000044 x2", if0.rs_data);
    end
    #1 rst = 1'b0;
    #1;
    n_checks++;
    if (if0.ready !== 1'b0 || if1.ready !== 1'b0 || if0.rs_data !== 64'h0 || if1.rs_data !== 128'h0) begin
      n_fail++;
      $display("FAIL async_reset_run: ready0=%b ready1=%b data=%h expected 0", if0.ready, if1.ready, if0.rs_data);
    end
    tick();
    rst = 1'b1;
    repeat (11) tick();
    // idx is now 12: restart the sequence from scratch
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if (if0.ready !== 1'b0 || if1.ready !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset_midclear: ready0=%b ready1=%b expected 0", if0.ready, if1.ready);
    end
    tick();
    rst = 1'b1;
    check_clear_window("restart_after_midclear_reset");
    #1;
    n_checks++;
    if (if0.rs_data !== 64'h0) begin
      n_fail++;
      $display("FAIL x4_after_reset_clear: got %h expected 0", if0.rs_data);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_bypass();
    test_multi_port();
    test_clear();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
